// File: rtl/mini_risc_wrapper.sv
// Single-cycle KGPminiRISC core: fetch, decode, execute and write back on every clk edge.
// Holds the 32x32 register file, PC and carry flag; instruction and data memories are external.
module mini_risc_wrapper (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_data,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic        dmem_we,
   input  logic [31:0] dmem_rdata,
   input  logic [4:0]  dbg_sel,
   output logic [31:0] dbg_data,
   output logic        carry
);

   localparam logic [5:0] OP_RTYPE = 6'd0;
   localparam logic [5:0] OP_ADDI  = 6'd1;
   localparam logic [5:0] OP_COMPI = 6'd2;
   localparam logic [5:0] OP_LW    = 6'd3;
   localparam logic [5:0] OP_SW    = 6'd4;
   localparam logic [5:0] OP_BR    = 6'd5;
   localparam logic [5:0] OP_BLTZ  = 6'd6;
   localparam logic [5:0] OP_BZ    = 6'd7;
   localparam logic [5:0] OP_BNZ   = 6'd8;
   localparam logic [5:0] OP_B     = 6'd9;
   localparam logic [5:0] OP_BL    = 6'd10;
   localparam logic [5:0] OP_BCY   = 6'd11;
   localparam logic [5:0] OP_BNCY  = 6'd12;

   localparam logic [4:0] F_ADD   = 5'd0;
   localparam logic [4:0] F_COMP  = 5'd1;
   localparam logic [4:0] F_AND   = 5'd2;
   localparam logic [4:0] F_XOR   = 5'd3;
   localparam logic [4:0] F_SHLL  = 5'd4;
   localparam logic [4:0] F_SHRL  = 5'd5;
   localparam logic [4:0] F_SHLLV = 5'd6;
   localparam logic [4:0] F_SHRLV = 5'd7;
   localparam logic [4:0] F_SHRA  = 5'd8;
   localparam logic [4:0] F_SHRAV = 5'd9;

   typedef struct packed {
      logic [5:0]  op;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  shamt;
      logic [4:0]  funct;
      logic [15:0] imm16;
      logic [25:0] imm26;
   } instr_t;

   logic [31:0] rf [0:31];
   logic [31:0] pc;
   logic        carry_q;

   instr_t      ins;
   logic [31:0] rs_val, rt_val;
   logic [31:0] sext16, sext26;
   logic [31:0] npc, bt, jt, pc_nx;
   logic [32:0] add_rr, add_ri;

   logic        wr_en;
   logic [4:0]  wr_idx;
   logic [31:0] wr_data;
   logic        carry_we;
   logic        carry_nx;

   // ---------------------------------------------------------------- decode
   always_comb begin
      ins.op    = imem_data[31:26];
      ins.rs    = imem_data[25:21];
      ins.rt    = imem_data[20:16];
      ins.shamt = imem_data[15:11];
      ins.funct = imem_data[4:0];
      ins.imm16 = imem_data[15:0];
      ins.imm26 = imem_data[25:0];
   end

   // rf[0] is cleared on reset and never written, the mux just makes r0 explicit
   assign rs_val = (ins.rs == 5'd0) ? 32'd0 : rf[ins.rs];
   assign rt_val = (ins.rt == 5'd0) ? 32'd0 : rf[ins.rt];

   assign sext16 = {{16{ins.imm16[15]}}, ins.imm16};
   assign sext26 = {{6{ins.imm26[25]}}, ins.imm26};

   assign npc = pc + 32'd4;
   assign bt  = npc + {sext16[29:0], 2'b00};
   assign jt  = npc + {sext26[29:0], 2'b00};

   assign add_rr = {1'b0, rs_val} + {1'b0, rt_val};
   assign add_ri = {1'b0, rs_val} + {1'b0, sext16};

   // ---------------------------------------------------------------- execute / writeback select
   always_comb begin
      wr_en    = 1'b0;
      wr_idx   = ins.rs;
      wr_data  = 32'd0;
      carry_we = 1'b0;
      carry_nx = carry_q;
      case (ins.op)
         OP_RTYPE: begin
            wr_en = 1'b1;
            case (ins.funct)
               F_ADD: begin
                  wr_data  = add_rr[31:0];
                  carry_we = 1'b1;
                  carry_nx = add_rr[32];
               end
               F_COMP:  wr_data = ~rt_val + 32'd1;
               F_AND:   wr_data = rs_val & rt_val;
               F_XOR:   wr_data = rs_val ^ rt_val;
               F_SHLL:  wr_data = rs_val << ins.shamt;
               F_SHRL:  wr_data = rs_val >> ins.shamt;
               F_SHLLV: wr_data = rs_val << rt_val[4:0];
               F_SHRLV: wr_data = rs_val >> rt_val[4:0];
               F_SHRA:  wr_data = $signed(rs_val) >>> ins.shamt;
               F_SHRAV: wr_data = $signed(rs_val) >>> rt_val[4:0];
               default: wr_en   = 1'b0;
            endcase
         end
         OP_ADDI: begin
            wr_en    = 1'b1;
            wr_data  = add_ri[31:0];
            carry_we = 1'b1;
            carry_nx = add_ri[32];
         end
         OP_COMPI: begin
            wr_en   = 1'b1;
            wr_data = ~sext16 + 32'd1;
         end
         OP_LW: begin
            wr_en   = 1'b1;
            wr_idx  = ins.rt;
            wr_data = dmem_rdata;
         end
         OP_BL: begin
            wr_en   = 1'b1;
            wr_idx  = 5'd31;
            wr_data = npc;
         end
         default: ;
      endcase
   end

   // ---------------------------------------------------------------- next PC
   always_comb begin
      pc_nx = npc;
      case (ins.op)
         OP_BR:   pc_nx = rs_val;
         OP_BLTZ: if (rs_val[31])        pc_nx = bt;
         OP_BZ:   if (rs_val == 32'd0)   pc_nx = bt;
         OP_BNZ:  if (rs_val != 32'd0)   pc_nx = bt;
         OP_B:    pc_nx = jt;
         OP_BL:   pc_nx = jt;
         OP_BCY:  if (carry_q)           pc_nx = jt;
         OP_BNCY: if (!carry_q)          pc_nx = jt;
         default: ;
      endcase
   end

   // ---------------------------------------------------------------- state
   always_ff @(posedge clk) begin
      if (rst) begin
         pc      <= 32'd0;
         carry_q <= 1'b0;
         for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
      end else begin
         pc <= pc_nx;
         if (carry_we) carry_q <= carry_nx;
         if (wr_en && (wr_idx != 5'd0)) rf[wr_idx] <= wr_data;
      end
   end

   // ---------------------------------------------------------------- outputs
   // Outputs are forced to 0 under reset so nothing X escapes before the first reset edge.
   assign imem_addr  = rst ? 32'd0 : pc;
   assign dmem_addr  = rst ? 32'd0 : rs_val + sext16;
   assign dmem_wdata = rst ? 32'd0 : rt_val;
   assign dmem_we    = (ins.op == OP_SW) && !rst;
   assign dbg_data   = (rst || dbg_sel == 5'd0) ? 32'd0 : rf[dbg_sel];
   assign carry      = carry_q;

endmodule

// File: tb/tb_mini_risc_wrapper.sv
// Directed bench for mini_risc_wrapper: small programs in a bench-side ROM,
// registers observed through the debug port, expected values worked out by hand.
module tb_mini_risc_wrapper;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] imem_addr, imem_data;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic        dmem_we;
   logic [4:0]  dbg_sel = 5'd0;
   logic [31:0] dbg_data;
   logic        carry;

   logic [31:0] imem [0:63];
   logic [31:0] dmem [0:63];

   int total = 0;
   int bad   = 0;

   localparam logic [31:0] NOP = 32'hFC00_0000;

   mini_risc_wrapper dut (
      .clk        (clk),
      .rst        (rst),
      .imem_addr  (imem_addr),
      .imem_data  (imem_data),
      .dmem_addr  (dmem_addr),
      .dmem_wdata (dmem_wdata),
      .dmem_we    (dmem_we),
      .dmem_rdata (dmem_rdata),
      .dbg_sel    (dbg_sel),
      .dbg_data   (dbg_data),
      .carry      (carry)
   );

   always #5 clk = ~clk;

   assign imem_data  = imem[imem_addr[7:2]];
   assign dmem_rdata = dmem[dmem_addr[7:2]];

   always @(posedge clk) if (dmem_we) dmem[dmem_addr[7:2]] <= dmem_wdata;

   function automatic logic [31:0] enc_r(input logic [4:0] f, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] sh);
      return {6'd0, rs, rt, sh, 6'd0, f};
   endfunction

   function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] imm);
      return {op, imm};
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   task automatic clr_mem();
      for (int i = 0; i < 64; i++) begin
         imem[i] = NOP;
         dmem[i] = 32'd0;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic get_reg(input logic [4:0] s, output logic [31:0] v);
      dbg_sel = s;
      #1 v = dbg_data;
   endtask

   logic [31:0] v;

   initial begin
      // ---------------- reset and arithmetic
      clr_mem();
      imem[0] = enc_i(6'd1, 5'd1, 5'd0, 16'd5);       // addi r1,5
      imem[1] = enc_i(6'd1, 5'd2, 5'd0, 16'hFFFD);    // addi r2,-3
      imem[2] = enc_r(5'd0, 5'd1, 5'd2, 5'd0);        // add r1,r2
      rst = 1'b1;
      @(posedge clk); #1;
      chk("rst_imem_addr", imem_addr, 32'd0);
      dbg_sel = 5'd1; #1;
      chk("rst_dbg", dbg_data, 32'd0);
      @(posedge clk); #1 rst = 1'b0;
      #1;
      chk("post_rst_pc", imem_addr, 32'd0);
      chk("post_rst_carry", {31'd0, carry}, 32'd0);
      get_reg(5'd1, v); chk("post_rst_r1", v, 32'd0);
      step(2);
      chk("addi_carry0", {31'd0, carry}, 32'd0);
      get_reg(5'd2, v); chk("addi_neg_r2", v, 32'hFFFF_FFFD);
      step(1);
      get_reg(5'd1, v); chk("add_r1", v, 32'd2);
      chk("add_carry", {31'd0, carry}, 32'd1);
      chk("pc_after3", imem_addr, 32'd12);

      // ---------------- shifts and negation
      clr_mem();
      imem[0]  = enc_i(6'd1, 5'd3, 5'd0, 16'd1);      // addi r3,1
      imem[1]  = enc_r(5'd4, 5'd3, 5'd0, 5'd31);      // shll r3,31
      imem[2]  = enc_i(6'd1, 5'd6, 5'd0, 16'd1);      // addi r6,1
      imem[3]  = enc_r(5'd4, 5'd6, 5'd0, 5'd31);      // shll r6,31
      imem[4]  = enc_r(5'd8, 5'd3, 5'd0, 5'd4);       // shra r3,4
      imem[5]  = enc_r(5'd5, 5'd6, 5'd0, 5'd4);       // shrl r6,4
      imem[6]  = enc_i(6'd2, 5'd4, 5'd0, 16'd1);      // compi r4,1
      imem[7]  = enc_i(6'd1, 5'd7, 5'd0, 16'hFFF0);   // addi r7,-16
      imem[8]  = enc_i(6'd1, 5'd8, 5'd0, 16'd2);      // addi r8,2
      imem[9]  = enc_r(5'd9, 5'd7, 5'd8, 5'd0);       // shrav r7,r8
      imem[10] = enc_r(5'd1, 5'd9, 5'd8, 5'd0);       // comp r9,r8
      imem[11] = enc_r(5'd3, 5'd7, 5'd9, 5'd0);       // xor r7,r9
      do_reset();
      step(10);
      get_reg(5'd3, v); chk("shra", v, 32'hF800_0000);
      get_reg(5'd6, v); chk("shrl", v, 32'h0800_0000);
      get_reg(5'd4, v); chk("compi", v, 32'hFFFF_FFFF);
      get_reg(5'd7, v); chk("shrav", v, 32'hFFFF_FFFC);
      step(2);
      get_reg(5'd9, v); chk("comp", v, 32'hFFFF_FFFE);
      get_reg(5'd7, v); chk("xor", v, 32'd2);

      // ---------------- memory
      clr_mem();
      imem[0] = enc_i(6'd1, 5'd1, 5'd0, 16'h1234);    // addi r1,0x1234
      imem[1] = enc_i(6'd4, 5'd0, 5'd1, 16'd8);       // sw r1,8(r0)
      imem[2] = enc_i(6'd3, 5'd0, 5'd5, 16'd8);       // lw r5,8(r0)
      do_reset();
      chk("no_we_addi", {31'd0, dmem_we}, 32'd0);
      step(1);
      chk("sw_we", {31'd0, dmem_we}, 32'd1);
      chk("sw_addr", dmem_addr, 32'd8);
      chk("sw_wdata", dmem_wdata, 32'h1234);
      step(1);
      chk("lw_we_low", {31'd0, dmem_we}, 32'd0);
      chk("mem_written", dmem[2], 32'h1234);
      step(1);
      get_reg(5'd5, v); chk("lw_r5", v, 32'h1234);

      // ---------------- branches
      clr_mem();
      imem[8]  = enc_i(6'd7, 5'd0, 5'd0, 16'd2);      // bz r0,+2 @0x20
      imem[11] = enc_i(6'd8, 5'd0, 5'd0, 16'd5);      // bnz r0,+5 @0x2C
      imem[16] = enc_j(6'd10, 26'h3FF_FFFF);          // bl -1 @0x40
      do_reset();
      step(8);
      chk("pc_at_bz", imem_addr, 32'h20);
      step(1);
      chk("bz_taken", imem_addr, 32'h2C);
      step(1);
      chk("bnz_not_taken", imem_addr, 32'h30);
      step(4);
      chk("pc_at_bl", imem_addr, 32'h40);
      step(1);
      chk("bl_target", imem_addr, 32'h40);
      get_reg(5'd31, v); chk("bl_link", v, 32'h44);

      // ---------------- carry branches
      clr_mem();
      imem[0]  = enc_i(6'd1, 5'd1, 5'd0, 16'hFFFF);   // addi r1,-1
      imem[1]  = enc_i(6'd1, 5'd2, 5'd0, 16'd1);      // addi r2,1
      imem[2]  = enc_r(5'd0, 5'd1, 5'd2, 5'd0);       // add r1,r2
      imem[3]  = enc_j(6'd11, 26'd3);                 // bcy +3 -> 28
      imem[7]  = enc_r(5'd0, 5'd2, 5'd2, 5'd0);       // add r2,r2
      imem[8]  = enc_j(6'd12, 26'd2);                 // bncy +2 -> 44
      imem[11] = enc_j(6'd11, 26'd5);                 // bcy, not taken
      do_reset();
      step(3);
      get_reg(5'd1, v); chk("add_wrap", v, 32'd0);
      chk("wrap_carry", {31'd0, carry}, 32'd1);
      step(1);
      chk("bcy_taken", imem_addr, 32'd28);
      step(1);
      get_reg(5'd2, v); chk("add_1p1", v, 32'd2);
      chk("carry_clr", {31'd0, carry}, 32'd0);
      step(1);
      chk("bncy_taken", imem_addr, 32'd44);
      step(1);
      chk("bcy_not_taken", imem_addr, 32'd48);

      // ---------------- mid-run reset
      clr_mem();
      imem[0] = enc_i(6'd1, 5'd1, 5'd1, 16'd1);       // addi r1,1
      imem[1] = enc_i(6'd4, 5'd0, 5'd1, 16'd0);       // sw r1,0(r0)
      imem[2] = enc_j(6'd9, 26'h3FF_FFFD);            // b -3 -> 0
      do_reset();
      step(4);
      chk("loop_pc", imem_addr, 32'd4);
      chk("loop_sw_we", {31'd0, dmem_we}, 32'd1);
      get_reg(5'd1, v); chk("loop_r1", v, 32'd2);
      rst = 1'b1;
      #1 chk("rst_gates_we", {31'd0, dmem_we}, 32'd0);
      @(posedge clk); #1 rst = 1'b0;
      #1;
      chk("midrst_pc", imem_addr, 32'd0);
      get_reg(5'd1, v); chk("midrst_r1", v, 32'd0);
      chk("midrst_no_store", dmem[0], 32'd1);

      // ---------------- r0 is immutable
      clr_mem();
      imem[0] = enc_i(6'd1, 5'd0, 5'd0, 16'd7);       // addi r0,7
      do_reset();
      step(1);
      get_reg(5'd0, v); chk("r0_zero", v, 32'd0);
      chk("r0_pc", imem_addr, 32'd4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
